p2_sprite_render: RTL and testbench
===================================

// Module: p2_sprite_render
// PURPOSE
//  Downstream consumer of the player-2 16x16 sprite ROM. Latches action, sequences animation frames on
//  frame_tick, builds rom_addr from the VGA beam position, consumes rom_bitmap one clock later and
//  emits a pipelined pixel-enable for the player-2 (blue) colour channel to the VGA mixer.
//  ROM address map: addr[9:6]=row 0..15, addr[5:3]=action, addr[2:0]=frame 0..3; bitmap bit 0 = opaque.
// PARAMETERS
//  SCALE_LOG2   2  each ROM bit drawn as 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels (box = 16<<SCALE_LOG2)
//  FRAME_TICKS  6  frame_tick pulses per animation frame (1..255)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active high
//  frame_tick   in   1   one-cycle pulse at start of vertical blank
//  action       in   3   requested action: 0 stay,1 forward,2 backward,3 punch,4 kick; 5..7 -> stay
//  p2_x         in  10   sprite box left edge, screen pixels
//  p2_y         in  10   sprite box top edge, screen pixels
//  facing_left  in   1   1 = mirror sprite horizontally
//  h_cnt        in  10   VGA column of current pixel
//  v_cnt        in  10   VGA row of current pixel
//  video_on     in   1   active display region
//  rom_addr     out 10   to sprite ROM (ROM registers addr; bitmap valid next clock)
//  rom_bitmap   in  16   from sprite ROM
//  pix_on       out  1   draw player-2 colour at pixel presented 2 clocks earlier
//  anim_busy    out  1   one-shot (punch/kick) animation in progress
//  anim_done    out  1   one-cycle pulse when a one-shot animation finishes
// BEHAVIOUR
//  Reset: cur_action=0, frame=0, tick_cnt=0, pix_on=0, anim_busy=0, anim_done=0, rom_addr=0, pipe cleared.
//  Animation FSM (updates only on frame_tick):
//   IDLE_LOOP: on tick, if mapped action != cur_action -> latch it, frame=0, tick_cnt=0;
//     if new action is 3/4 -> ONE_SHOT, anim_busy=1. Else tick_cnt++; at FRAME_TICKS-1 wrap to 0
//     and frame=frame+1 mod 4 (loop).
//   ONE_SHOT: action input ignored; frame advances as above; on the tick that would leave frame 3 ->
//     frame=0, cur_action=0, anim_busy=0, anim_done=1 for that cycle, -> IDLE_LOOP.
//  Action change + frame_tick same cycle: change wins, counters restart at 0 (no advance that tick).
//  frame/cur_action never change except on frame_tick, so no mid-screen tearing.
//  Pixel pipeline, latency exactly 2 clocks h_cnt/v_cnt -> pix_on:
//   S0: dx=h_cnt-p2_x, dy=v_cnt-p2_y (11-bit, sign checked); in_box = video_on & h_cnt>=p2_x &
//     v_cnt>=p2_y & dx<(16<<SCALE_LOG2) & dy<(16<<SCALE_LOG2). No wrap: box clipped at screen edges.
//     row=dy>>SCALE_LOG2, col=dx>>SCALE_LOG2; rom_addr={row,cur_action,frame[2:0]} driven
//     combinationally from S0 inputs; register in_box, col.
//   S1: bit = facing_left ? rom_bitmap[col] : rom_bitmap[15-col];
//     pix_on <= in_box_q & ~bit (registered).
//  Outside box or video_on=0 -> pix_on=0 regardless of rom_bitmap.
//  rst mid-line: pix_on=0 next clock; pipeline refills, valid 2 clocks after rst deasserts.
// CONFIGURATION
//  P2_SPRITE_OUTLINE_EN defined: pix_on also forced to 1 on the one-pixel border of the in_box region
//   (dx==0, dx==box-1, dy==0, dy==box-1), same 2-clock latency, for hitbox debugging.
//  Not defined: no border logic; pix_on depends only on bitmap.
// TESTING
//  1 rst held 3 clks with frame_tick=1 -> pix_on=0, anim_busy=0, frame=0, rom_addr=0 throughout.
//  2 p2_x=100,p2_y=200,SCALE_LOG2=2, action=0, h=100,v=200 -> rom_addr=10'o0000; bitmap 16'hFC3F:
//    pix_on=1 2 clks after h=124..139 (cols 6..9), 0 at h=120,140; h=99 or h=164 -> 0.
//  3 facing_left=1, bitmap 16'h7FFF -> pix_on=1 only for col 15 (h=160..163 with p2_x=100).
//  4 action 0->3 with tick: frame 0,1,2,3 each FRAME_TICKS ticks; anim_busy=1 for 24 ticks, then
//    anim_done pulse, frame=0, action=0; action=4 during one-shot ignored.
//  5 action=1 held: frame sequence 0,1,2,3,0 at ticks 6,12,18,24; action=7 -> latched as 0.
//  6 p2_x=1000 (box off right edge): h=1000..1023 drawn per bitmap, no wrap to h=0..39.

Source files
------------

// File: rtl/p2_sprite_render.sv
// Player-2 sprite renderer: animation sequencing, sprite ROM addressing and a 2-clock pixel pipeline.
// Optional build macro P2_SPRITE_OUTLINE_EN draws the sprite box border for hitbox debugging.
module p2_sprite_render #(
  parameter int SCALE_LOG2  = 2,
  parameter int FRAME_TICKS = 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_tick,
  input  logic [2:0]  i_action,
  input  logic [9:0]  i_p2_x,
  input  logic [9:0]  i_p2_y,
  input  logic        i_facing_left,
  input  logic [9:0]  i_h_cnt,
  input  logic [9:0]  i_v_cnt,
  input  logic        i_video_on,
  output logic [9:0]  o_rom_addr,
  input  logic [15:0] i_rom_bitmap,
  output logic        o_pix_on,
  output logic        o_anim_busy,
  output logic        o_anim_done
);

  localparam logic [10:0] BOX_W     = 11'(16 << SCALE_LOG2);
  localparam logic [7:0]  TICK_LAST = 8'(FRAME_TICKS - 1);

  typedef enum logic [0:0] {
    ST_IDLE_LOOP = 1'b0,
    ST_ONE_SHOT  = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cur_action, w_cur_action_nxt;
  logic [1:0]  r_frame, w_frame_nxt;
  logic [7:0]  r_tick_cnt, w_tick_cnt_nxt;
  logic        r_anim_busy, w_anim_busy_nxt;
  logic        r_anim_done, w_anim_done_nxt;
  logic [2:0]  w_action_map;
  logic        w_tick_wrap;

  logic [10:0] w_dx, w_dy;
  logic        w_in_box;
  logic [3:0]  w_row, w_col;
  logic        w_bit;
  logic        r_in_box;
  logic [3:0]  r_col;
  logic        r_pix_on;

  // Unsupported action codes behave as "stay".
  assign w_action_map = (i_action > 3'd4) ? 3'd0 : i_action;
  assign w_tick_wrap  = (r_tick_cnt == TICK_LAST);

  // Animation next-state: everything moves only on frame_tick so the sprite never tears mid-screen.
  always_comb begin
    w_state_nxt      = r_state;
    w_cur_action_nxt = r_cur_action;
    w_frame_nxt      = r_frame;
    w_tick_cnt_nxt   = r_tick_cnt;
    w_anim_busy_nxt  = r_anim_busy;
    w_anim_done_nxt  = 1'b0;
    if (i_frame_tick) begin
      case (r_state)
        ST_IDLE_LOOP: begin
          if (w_action_map != r_cur_action) begin
            w_cur_action_nxt = w_action_map;
            w_frame_nxt      = 2'd0;
            w_tick_cnt_nxt   = 8'd0;
            if ((w_action_map == 3'd3) || (w_action_map == 3'd4)) begin
              w_state_nxt     = ST_ONE_SHOT;
              w_anim_busy_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE_LOOP;
            end
          end else if (w_tick_wrap) begin
            w_tick_cnt_nxt = 8'd0;
            w_frame_nxt    = r_frame + 2'd1;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 8'd1;
          end
        end
        ST_ONE_SHOT: begin
          if (w_tick_wrap) begin
            w_tick_cnt_nxt = 8'd0;
            if (r_frame == 2'd3) begin
              w_frame_nxt      = 2'd0;
              w_cur_action_nxt = 3'd0;
              w_anim_busy_nxt  = 1'b0;
              w_anim_done_nxt  = 1'b1;
              w_state_nxt      = ST_IDLE_LOOP;
            end else begin
              w_frame_nxt = r_frame + 2'd1;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 8'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE_LOOP;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Animation state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE_LOOP;
      r_cur_action <= 3'd0;
      r_frame      <= 2'd0;
      r_tick_cnt   <= 8'd0;
      r_anim_busy  <= 1'b0;
      r_anim_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_action <= w_cur_action_nxt;
      r_frame      <= w_frame_nxt;
      r_tick_cnt   <= w_tick_cnt_nxt;
      r_anim_busy  <= w_anim_busy_nxt;
      r_anim_done  <= w_anim_done_nxt;
    end
  end

  // 11-bit differences: bit 10 set means the beam is left of / above the box, so no wrap-around.
  assign w_dx     = {1'b0, i_h_cnt} - {1'b0, i_p2_x};
  assign w_dy     = {1'b0, i_v_cnt} - {1'b0, i_p2_y};
  assign w_in_box = i_video_on & ~w_dx[10] & ~w_dy[10] & (w_dx < BOX_W) & (w_dy < BOX_W);
  assign w_row    = w_dy[SCALE_LOG2 +: 4];
  assign w_col    = w_dx[SCALE_LOG2 +: 4];

  assign o_rom_addr = i_rst ? 10'd0 : {w_row, r_cur_action, 1'b0, r_frame};

  // Column select; bitmap bit 15 is the leftmost column unless mirrored.
  always_comb begin
    w_bit = 1'b1;
    if (i_facing_left) begin
      w_bit = i_rom_bitmap[r_col];
    end else begin
      w_bit = i_rom_bitmap[4'd15 - r_col];
    end
  end

`ifdef P2_SPRITE_OUTLINE_EN
  logic w_border;
  logic r_border;

  assign w_border = w_in_box & ((w_dx == 11'd0) | (w_dx == (BOX_W - 11'd1)) |
                                (w_dy == 11'd0) | (w_dy == (BOX_W - 11'd1)));

  // Pixel pipeline with box outline forced on.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_box <= 1'b0;
      r_col    <= 4'd0;
      r_border <= 1'b0;
      r_pix_on <= 1'b0;
    end else begin
      r_in_box <= w_in_box;
      r_col    <= w_col;
      r_border <= w_border;
      r_pix_on <= r_in_box & (~w_bit | r_border);
    end
  end
`else
  // Pixel pipeline: stage 0 registers box membership and column, stage 1 applies the bitmap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_box <= 1'b0;
      r_col    <= 4'd0;
      r_pix_on <= 1'b0;
    end else begin
      r_in_box <= w_in_box;
      r_col    <= w_col;
      r_pix_on <= r_in_box & ~w_bit;
    end
  end
`endif

  assign o_pix_on    = r_pix_on;
  assign o_anim_busy = r_anim_busy;
  assign o_anim_done = r_anim_done;

endmodule

// File: tb/tb_p2_sprite_render.sv
// Self-checking bench for p2_sprite_render: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the animation rules and sprite geometry.
module tb_p2_sprite_render;

  localparam int SCALE_LOG2  = 2;
  localparam int FRAME_TICKS = 6;
  localparam int BOX         = 16 << SCALE_LOG2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic [2:0]  action = 3'd0;
  logic [9:0]  p2_x = 10'd0, p2_y = 10'd0;
  logic        facing_left = 1'b0;
  logic [9:0]  h_cnt = 10'd0, v_cnt = 10'd0;
  logic        video_on = 1'b0;
  logic [9:0]  rom_addr;
  logic [15:0] rom_bitmap = 16'h0000;
  logic        pix_on, anim_busy, anim_done;

  logic [15:0] rom_tbl [0:1023];

  p2_sprite_render #(.SCALE_LOG2(SCALE_LOG2), .FRAME_TICKS(FRAME_TICKS)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_tick(frame_tick), .i_action(action),
    .i_p2_x(p2_x), .i_p2_y(p2_y), .i_facing_left(facing_left),
    .i_h_cnt(h_cnt), .i_v_cnt(v_cnt), .i_video_on(video_on),
    .o_rom_addr(rom_addr), .i_rom_bitmap(rom_bitmap),
    .o_pix_on(pix_on), .o_anim_busy(anim_busy), .o_anim_done(anim_done)
  );

  always #5 clk = ~clk;

  // Sprite ROM: registered address, data one clock later.
  always @(posedge clk) rom_bitmap <= rom_tbl[rom_addr];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int m_cur = 0, m_frame = 0, m_tick = 0;
  bit m_one_shot = 0, m_busy = 0, m_done = 0;
  bit m_s1 = 0, m_pix = 0;

  int pix_by_h [0:1023];
  int prev_h = -1;
  int rec_h  = -1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  function automatic int exp_addr();
    int dy, row;
    if (rst) return 0;
    dy  = (int'(v_cnt) - int'(p2_y)) & 2047;
    row = (dy >> SCALE_LOG2) & 15;
    return row * 64 + m_cur * 8 + m_frame;
  endfunction

  function automatic bit exp_stage(input int addr);
    int dx, dy, col;
    logic [15:0] w;
    bit inb, b, r;
    dx  = int'(h_cnt) - int'(p2_x);
    dy  = int'(v_cnt) - int'(p2_y);
    inb = video_on && dx >= 0 && dy >= 0 && dx < BOX && dy < BOX;
    if (!inb) return 1'b0;
    col = dx >> SCALE_LOG2;
    w   = rom_tbl[addr];
    b   = facing_left ? w[col] : w[15 - col];
    r   = !b;
`ifdef P2_SPRITE_OUTLINE_EN
    if (dx == 0 || dx == BOX - 1 || dy == 0 || dy == BOX - 1) r = 1'b1;
`endif
    return r;
  endfunction

  // Animation rules applied once per frame_tick.
  task automatic model_tick();
    int mapped;
    mapped = (int'(action) > 4) ? 0 : int'(action);
    if (!m_one_shot && mapped != m_cur) begin
      m_cur = mapped; m_frame = 0; m_tick = 0;
      if (mapped == 3 || mapped == 4) begin m_one_shot = 1; m_busy = 1; end
    end else begin
      m_tick++;
      if (m_tick == FRAME_TICKS) begin
        m_tick = 0;
        if (m_one_shot && m_frame == 3) begin
          m_frame = 0; m_cur = 0; m_one_shot = 0; m_busy = 0; m_done = 1;
        end else begin
          m_frame = (m_frame + 1) % 4;
        end
      end
    end
  endtask

  task automatic run_cycle();
    int  a;
    bit  s1n;
    #1;
    a = exp_addr();
    check_eq("rom_addr", int'(rom_addr), a);
    s1n = exp_stage(a);
    @(posedge clk);
    if (rst) begin
      m_pix = 0; m_s1 = 0; m_cur = 0; m_frame = 0; m_tick = 0;
      m_one_shot = 0; m_busy = 0; m_done = 0;
    end else begin
      m_pix = m_s1; m_s1 = s1n; m_done = 0;
      if (frame_tick) model_tick();
    end
    #1;
    check_eq("pix_on", int'(pix_on), int'(m_pix));
    check_eq("anim_busy", int'(anim_busy), int'(m_busy));
    check_eq("anim_done", int'(anim_done), int'(m_done));
    if (prev_h >= 0) pix_by_h[prev_h] = int'(pix_on);
    prev_h = rec_h;
    rec_h  = -1;
  endtask

  task automatic flush();
    video_on = 1'b0;
    repeat (3) run_cycle();
  endtask

  task automatic sweep(input int v, input int h0, input int h1);
    v_cnt = 10'(v);
    video_on = 1'b1;
    for (int h = h0; h <= h1; h++) begin
      h_cnt = 10'(h);
      rec_h = h;
      run_cycle();
    end
    flush();
  endtask

  task automatic fill_rom(input logic [15:0] val);
    for (int i = 0; i < 1024; i++) rom_tbl[i] = val;
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    run_cycle();
    frame_tick = 1'b0;
    run_cycle();
  endtask

  initial begin
    int n, got_done;
    fill_rom(16'hFFFF);

    // Reset held with frame_tick asserted.
    rst = 1'b1; frame_tick = 1'b1; action = 3'd3; video_on = 1'b1;
    h_cnt = 10'd110; v_cnt = 10'd210; p2_x = 10'd100; p2_y = 10'd200;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check_eq("rst_rom_addr", int'(rom_addr), 0);
      check_eq("rst_pix_on", int'(pix_on), 0);
      check_eq("rst_busy", int'(anim_busy), 0);
    end
    rst = 1'b0; frame_tick = 1'b0; action = 3'd0;
    flush();

    // Box origin address and unmirrored bitmap.
    fill_rom(16'hFC3F);
    h_cnt = 10'd100; v_cnt = 10'd200; video_on = 1'b1;
    #1 check_eq("origin_addr", int'(rom_addr), 0);
    flush();
    sweep(204, 96, 170);
    check_eq("h124", pix_by_h[124], 1);
    check_eq("h139", pix_by_h[139], 1);
    check_eq("h120", pix_by_h[120], 0);
    check_eq("h140", pix_by_h[140], 0);
    check_eq("h99", pix_by_h[99], 0);
    check_eq("h164", pix_by_h[164], 0);

    // Mirrored.
    facing_left = 1'b1;
    fill_rom(16'h7FFF);
    sweep(204, 150, 170);
    check_eq("mir_h160", pix_by_h[160], 1);
    check_eq("mir_h163", pix_by_h[163], 1);
    check_eq("mir_h159", pix_by_h[159], 0);
    check_eq("mir_h164", pix_by_h[164], 0);
    facing_left = 1'b0;

    // One-shot punch; kick request during it is ignored.
    action = 3'd3;
    do_tick();
    check_eq("oneshot_busy", int'(anim_busy), 1);
    action = 3'd4;
    n = 0; got_done = 0;
    while (!got_done && n < 40) begin
      frame_tick = 1'b1;
      run_cycle();
      n++;
      if (anim_done) got_done = 1;
      frame_tick = 1'b0;
      run_cycle();
    end
    check_eq("oneshot_len", n, 4 * FRAME_TICKS);
    check_eq("oneshot_end_busy", int'(anim_busy), 0);
    check_eq("oneshot_end_act", int'(rom_addr[5:3]), 0);
    check_eq("oneshot_end_frame", int'(rom_addr[2:0]), 0);
    action = 3'd0;

    // Looping forward walk, then unsupported code 7.
    action = 3'd1;
    do_tick();
    for (int t = 1; t <= 4 * FRAME_TICKS; t++) begin
      do_tick();
      check_eq("loop_frame", int'(rom_addr[2:0]), (t / FRAME_TICKS) % 4);
    end
    check_eq("loop_busy", int'(anim_busy), 0);
    action = 3'd7;
    do_tick();
    check_eq("act7_map", int'(rom_addr[5:3]), 0);
    action = 3'd0;

    // Box hanging off the right edge: no wrap to the left.
    fill_rom(16'h0000);
    p2_x = 10'd1000; p2_y = 10'd200;
    sweep(204, 990, 1023);
    sweep(204, 0, 45);
    check_eq("edge_h1000", pix_by_h[1000], 1);
    check_eq("edge_h1023", pix_by_h[1023], 1);
    check_eq("edge_h999", pix_by_h[999], 0);
    check_eq("edge_h0", pix_by_h[0], 0);
    check_eq("edge_h39", pix_by_h[39], 0);

    // Randomized traffic.
    for (int i = 0; i < 1024; i++) rom_tbl[i] = 16'($urandom);
    for (int seg = 0; seg < 16; seg++) begin
      facing_left = 1'($urandom);
      p2_x = 10'($urandom);
      p2_y = 10'($urandom);
      for (int c = 0; c < 120; c++) begin
        h_cnt      = 10'(int'(p2_x) + int'($urandom_range(0, 70)) - 3);
        v_cnt      = 10'(int'(p2_y) + int'($urandom_range(0, 70)) - 3);
        video_on   = ($urandom_range(0, 7) != 0);
        frame_tick = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 15) == 0) action = 3'($urandom);
        rst        = ($urandom_range(0, 199) == 0);
        run_cycle();
      end
      rst = 1'b0; frame_tick = 1'b0;
      flush();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
